// File: rtl/regfile_mp_if.sv
// Register file access bundle: read ports, two write ports, scoreboard issue/clear controls.
// The core side drives through master; the register file listens through slave.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pending;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we1;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                wb_clr0;
    logic                wb_clr1;

    modport master (
        output rd_addr, we0, wa0, wd0, we1, wa1, wd1,
               iss_valid, iss_rd, wb_clr0, wb_clr1,
        input  rd_data, rd_pending
    );

    modport slave (
        input  rd_addr, we0, wa0, wd0, we1, wa1, wd1,
               iss_valid, iss_rd, wb_clr0, wb_clr1,
        output rd_data, rd_pending
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with pending scoreboard; reads are combinational (0 cycles), writes land at the edge.
// No backpressure: every write, issue and clear is accepted in the cycle it is presented.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clock,
    input  logic         reset,
    regfile_mp_if.slave  rf
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] rf_q, rf_d;
    logic [NREG-1:0]           pending_q, pending_d;

    function automatic logic is_x0(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Port 1 is applied after port 0 so it wins an address collision;
    // a set is applied after the clears so a new producer wins.
    always_comb begin
        rf_d      = rf_q;
        pending_d = pending_q;
        if (rf.we0 && !is_x0(rf.wa0)) rf_d[rf.wa0] = rf.wd0;
        if (rf.we1 && !is_x0(rf.wa1)) rf_d[rf.wa1] = rf.wd1;
        if (rf.wb_clr0) pending_d[rf.wa0] = 1'b0;
        if (rf.wb_clr1) pending_d[rf.wa1] = 1'b0;
        if (rf.iss_valid && !is_x0(rf.iss_rd)) pending_d[rf.iss_rd] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_q      <= '0;
            pending_q <= '0;
        end else begin
            rf_q      <= rf_d;
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            pend;

        assign addr = rf.rd_addr[i*AW +: AW];

        always_comb begin
            data = rf_q[addr];
            pend = pending_q[addr];
            if (BYPASS != 0) begin
                if (rf.we1 && rf.wa1 == addr)      data = rf.wd1;
                else if (rf.we0 && rf.wa0 == addr) data = rf.wd0;
                if ((rf.wb_clr0 && rf.wa0 == addr) || (rf.wb_clr1 && rf.wa1 == addr))
                    pend = 1'b0;
            end
            // Bypass must not leak through x0 or while state is held in reset.
            if (is_x0(addr) || reset) begin
                data = '0;
                pend = 1'b0;
            end
        end

        assign rf.rd_data[i*XLEN +: XLEN] = data;
        assign rf.rd_pending[i]           = pend;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomised checks of regfile_mp with bypass on (dut_a) and off (dut_b).
module tb_regfile_mp;
    logic clock;
    logic reset;
    int   n_chk;
    int   n_fail;

    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(3)) ifa ();
    regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(3)) ifb ();

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(3), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clock(clock), .reset(reset), .rf(ifa));
    regfile_mp #(.XLEN(32), .NREG(32), .NRD(3), .ZERO_REG(1), .BYPASS(0))
        dut_b (.clock(clock), .reset(reset), .rf(ifb));

    assign ifb.rd_addr   = ifa.rd_addr;
    assign ifb.we0       = ifa.we0;
    assign ifb.wa0       = ifa.wa0;
    assign ifb.wd0       = ifa.wd0;
    assign ifb.we1       = ifa.we1;
    assign ifb.wa1       = ifa.wa1;
    assign ifb.wd1       = ifa.wd1;
    assign ifb.iss_valid = ifa.iss_valid;
    assign ifb.iss_rd    = ifa.iss_rd;
    assign ifb.wb_clr0   = ifa.wb_clr0;
    assign ifb.wb_clr1   = ifa.wb_clr1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] rf_m [32];
    logic        pend_m [32];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] a_dat(input int p);
        return ifa.rd_data[p*32 +: 32];
    endfunction
    function automatic logic [31:0] b_dat(input int p);
        return ifb.rd_data[p*32 +: 32];
    endfunction
    function automatic logic [31:0] a_pnd(input int p);
        return {31'd0, ifa.rd_pending[p]};
    endfunction
    function automatic logic [31:0] b_pnd(input int p);
        return {31'd0, ifb.rd_pending[p]};
    endfunction

    task automatic set_ra(input int p, input logic [4:0] a);
        ifa.rd_addr[p*5 +: 5] = a;
    endtask

    task automatic idle();
        ifa.we0 = 0; ifa.wa0 = 0; ifa.wd0 = 0;
        ifa.we1 = 0; ifa.wa1 = 0; ifa.wd1 = 0;
        ifa.iss_valid = 0; ifa.iss_rd = 0;
        ifa.wb_clr0 = 0; ifa.wb_clr1 = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] exp_dat(input bit byp, input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (byp && ifa.we1 && ifa.wa1 == a) return ifa.wd1;
        if (byp && ifa.we0 && ifa.wa0 == a) return ifa.wd0;
        return rf_m[a];
    endfunction

    function automatic logic [31:0] exp_pnd(input bit byp, input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (byp && ((ifa.wb_clr0 && ifa.wa0 == a) || (ifa.wb_clr1 && ifa.wa1 == a))) return 32'd0;
        return {31'd0, pend_m[a]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle();
        ifa.rd_addr = '0;
        set_ra(0, 5'd5);
        #2;
        check_val("rst_data", a_dat(0), 32'd0);
        check_val("rst_pend", {29'd0, ifa.rd_pending}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // 1: reset mid-cycle zeroes state immediately; writes under reset are lost
        ifa.we0 = 1; ifa.wa0 = 5; ifa.wd0 = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        check_val("t1_load", a_dat(0), 32'hDEADBEEF);
        ifa.iss_valid = 1; ifa.iss_rd = 5;
        tick();
        idle();
        #1;
        check_val("t1_pend_set", a_pnd(0), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_val("t1_rst_data", a_dat(0), 32'd0);
        check_val("t1_rst_pend", a_pnd(0), 32'd0);
        ifa.we1 = 1; ifa.wa1 = 5; ifa.wd1 = 32'hCAFEF00D;
        #1;
        check_val("t1_rst_byp", a_dat(0), 32'd0);
        tick();
        idle();
        #1 reset = 1'b0;
        #1;
        check_val("t1_lost_a", a_dat(0), 32'd0);
        check_val("t1_lost_b", b_dat(0), 32'd0);
        tick();

        // 2: write then read, same-cycle bypass vs none
        ifa.we0 = 1; ifa.wa0 = 3; ifa.wd0 = 32'h12345678;
        set_ra(0, 5'd3);
        #1;
        check_val("t2_byp_a", a_dat(0), 32'h12345678);
        check_val("t2_nobyp_b", b_dat(0), 32'd0);
        tick();
        idle();
        #1;
        check_val("t2_next_a", a_dat(0), 32'h12345678);
        check_val("t2_next_b", b_dat(0), 32'h12345678);

        // 3: write collision, port 1 wins
        ifa.we0 = 1; ifa.wa0 = 7; ifa.wd0 = 32'h1111;
        ifa.we1 = 1; ifa.wa1 = 7; ifa.wd1 = 32'h2222;
        set_ra(1, 5'd7);
        #1;
        check_val("t3_byp_a", a_dat(1), 32'h2222);
        check_val("t3_nobyp_b", b_dat(1), 32'd0);
        tick();
        idle();
        #1;
        check_val("t3_next_a", a_dat(1), 32'h2222);
        check_val("t3_next_b", b_dat(1), 32'h2222);

        // 4: x0 ignores writes and issues
        ifa.we1 = 1; ifa.wa1 = 0; ifa.wd1 = 32'hFFFFFFFF;
        ifa.iss_valid = 1; ifa.iss_rd = 0;
        set_ra(2, 5'd0);
        #1;
        check_val("t4_same_a", a_dat(2), 32'd0);
        check_val("t4_same_b", b_dat(2), 32'd0);
        tick();
        idle();
        #1;
        check_val("t4_next_a", a_dat(2), 32'd0);
        check_val("t4_pend_a", a_pnd(2), 32'd0);

        // 5: scoreboard set, set-wins-over-clear, clear
        ifa.iss_valid = 1; ifa.iss_rd = 9;
        set_ra(0, 5'd9);
        #1;
        check_val("t5_pre", a_pnd(0), 32'd0);
        tick();
        idle();
        #1;
        check_val("t5_set", a_pnd(0), 32'd1);
        ifa.wb_clr0 = 1; ifa.wa0 = 9; ifa.iss_valid = 1; ifa.iss_rd = 9;
        #1;
        check_val("t5_mask_a", a_pnd(0), 32'd0);
        check_val("t5_nomask_b", b_pnd(0), 32'd1);
        tick();
        idle();
        #1;
        check_val("t5_setwins", a_pnd(0), 32'd1);
        ifa.wb_clr0 = 1; ifa.wa0 = 9;
        tick();
        idle();
        #1;
        check_val("t5_clr_a", a_pnd(0), 32'd0);
        check_val("t5_clr_b", b_pnd(0), 32'd0);
        ifa.iss_valid = 1; ifa.iss_rd = 4;
        set_ra(1, 5'd4);
        tick();
        idle();
        ifa.wb_clr1 = 1; ifa.wa1 = 4;
        tick();
        idle();
        #1;
        check_val("t5_clr1", a_pnd(1), 32'd0);

        // 6: three read ports
        ifa.we0 = 1; ifa.wa0 = 1; ifa.wd0 = 32'hA;
        ifa.we1 = 1; ifa.wa1 = 2; ifa.wd1 = 32'hB;
        tick();
        idle();
        set_ra(0, 5'd1); set_ra(1, 5'd2); set_ra(2, 5'd1);
        #1;
        check_val("t6_p0", a_dat(0), 32'hA);
        check_val("t6_p1", a_dat(1), 32'hB);
        check_val("t6_p2", a_dat(2), 32'hA);

        // Random regression against a reference model, from a clean reset
        #1 reset = 1'b1;
        for (int r = 0; r < 32; r++) begin
            rf_m[r]   = 32'd0;
            pend_m[r] = 1'b0;
        end
        tick();
        reset = 1'b0;
        tick();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            for (int p = 0; p < 3; p++)
                set_ra(p, narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)));
            ifa.we0       = $urandom_range(0, 1) == 1;
            ifa.wa0       = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ifa.wd0       = $urandom;
            ifa.we1       = $urandom_range(0, 1) == 1;
            ifa.wa1       = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ifa.wd1       = $urandom;
            ifa.iss_valid = $urandom_range(0, 1) == 1;
            ifa.iss_rd    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ifa.wb_clr0   = $urandom_range(0, 2) == 0;
            ifa.wb_clr1   = $urandom_range(0, 2) == 0;
            #1;
            for (int p = 0; p < 3; p++) begin
                logic [4:0] a;
                a = ifa.rd_addr[p*5 +: 5];
                check_val("rnd_dat_a", a_dat(p), exp_dat(1'b1, a));
                check_val("rnd_dat_b", b_dat(p), exp_dat(1'b0, a));
                check_val("rnd_pnd_a", a_pnd(p), exp_pnd(1'b1, a));
                check_val("rnd_pnd_b", b_pnd(p), exp_pnd(1'b0, a));
            end
            if (ifa.we0 && ifa.wa0 != 0) rf_m[ifa.wa0] = ifa.wd0;
            if (ifa.we1 && ifa.wa1 != 0) rf_m[ifa.wa1] = ifa.wd1;
            if (ifa.wb_clr0) pend_m[ifa.wa0] = 1'b0;
            if (ifa.wb_clr1) pend_m[ifa.wa1] = 1'b0;
            if (ifa.iss_valid && ifa.iss_rd != 0) pend_m[ifa.iss_rd] = 1'b1;
            tick();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
